// File: rtl/cex_pkg.sv
// cex_pkg: shared target state encoding, driver FSM states, error codes and target transition function
package cex_pkg;
  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_FAIL} fsm_t;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_UNREACH  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
  function automatic logic [1:0] cex_next(input logic [1:0] s, input logic i);
    return s == S0 ? S1 : s == S1 ? (i ? S2 : S0) : s == S2 ? (i ? S3 : S2) : S3;
  endfunction
endpackage

// File: rtl/cex_shadow.sv
// cex_shadow: free-running shadow of the target state and observed-flag mismatch detect
module cex_shadow import cex_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       i,
  input  logic       p,
  input  logic       q,
  output logic [1:0] shadow,
  output logic       mismatch
);
  always_ff @(posedge clock or posedge reset)
    if (reset) shadow <= S0;
    else shadow <= cex_next(shadow, i);
  assign mismatch = (p != (shadow == S1)) || (q != (shadow == S2));
endmodule

// File: rtl/cex_driver.sv
// cex_driver: closed-loop driver steering the cex target to a goal state; trace storage under CEX_DRIVER_TRACE_EN
module cex_driver import cex_pkg::*; #(
  parameter int MAX_STEPS = 15,
  parameter int DEPTH = 16,
  localparam int SW = $clog2(MAX_STEPS + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    goal,
  input  logic          p,
  input  logic          q,
  output logic          i,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [1:0]    err_code,
  output logic [SW-1:0] steps,
  input  logic [AW-1:0] trace_addr,
  output logic          trace_data
);
  fsm_t st;
  logic [1:0] goal_q, shadow;
  logic mismatch, drive, adv;
  cex_shadow u_shadow (.clock, .reset, .i, .p, .q, .shadow, .mismatch);
  // i is held low on deciding cycles so the target stays where the run ended
  assign drive = st == ST_RUN && shadow != goal_q && steps != SW'(MAX_STEPS);
  assign i = drive && goal_q[1] && (shadow == S1 || shadow == S2);
  assign adv = drive && !mismatch && shadow != S3;
  assign busy = st == ST_RUN;
  assign done = st == ST_DONE;
  assign fail = st == ST_FAIL;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st <= ST_IDLE;
      goal_q <= S0;
      steps <= '0;
      err_code <= ERR_NONE;
    end else if (st != ST_RUN) begin
      if (start) begin
        st <= ST_RUN;
        goal_q <= goal;
        steps <= '0;
        err_code <= ERR_NONE;
      end
    end else if (mismatch) begin
      st <= ST_FAIL;
      err_code <= ERR_MISMATCH;
    end else if (shadow == goal_q) st <= ST_DONE;
    else if (shadow == S3) begin
      st <= ST_FAIL;
      err_code <= ERR_UNREACH;
    end else if (steps == SW'(MAX_STEPS)) begin
      st <= ST_FAIL;
      err_code <= ERR_TIMEOUT;
    end else steps <= steps + 1'b1;
`ifdef CEX_DRIVER_TRACE_EN
  logic [DEPTH-1:0] mem;
  always_ff @(posedge clock)
    if (adv) mem[AW'(steps)] <= i;
  assign trace_data = mem[trace_addr];
`else
  logic unused_trace;
  assign unused_trace = ^{trace_addr, adv};
  assign trace_data = 1'b0;
`endif
endmodule

// File: tb/tb_cex_driver.sv
// tb_cex_driver: table-driven scoreboard bench with behavioural targets for two driver configurations
module tb_cex_driver;
  import cex_pkg::*;
`ifdef CEX_DRIVER_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  typedef struct {
    bit inst; bit clr; bit poke; logic [1:0] goal;
    bit done; int err; int steps; logic [7:0] tr; int tgt;
  } vec_t;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, tgt_clr = 1'b1, sel = 1'b0;
  logic ovr = 1'b0, pv = 1'b0, qv = 1'b0;
  logic [1:0] goal = 2'd0, tgt0, tgt1, tsel, err0, err1;
  logic [3:0] trace_addr = 4'd0, steps0;
  logic [1:0] steps1;
  logic start0, start1, p0, q0, p1, q1, i0, i1, busy0, busy1, done0, done1, fail0, fail1, td0, td1;
  logic iw, bsy, dn, fl, tdw;
  int stw, erw;
  int pass = 0, total = 0;
  vec_t tv[9];
  vec_t sb[$];

  initial forever #5 clock = ~clock;

  assign start0 = start && !sel;
  assign start1 = start && sel;
  assign p0 = ovr ? pv : tgt0 == S1;
  assign q0 = ovr ? qv : tgt0 == S2;
  assign p1 = tgt1 == S1;
  assign q1 = tgt1 == S2;
  assign tsel = sel ? tgt1 : tgt0;
  assign iw = sel ? i1 : i0;
  assign bsy = sel ? busy1 : busy0;
  assign dn = sel ? done1 : done0;
  assign fl = sel ? fail1 : fail0;
  assign tdw = sel ? td1 : td0;
  assign stw = sel ? int'(steps1) : int'(steps0);
  assign erw = sel ? int'(err1) : int'(err0);

  // behavioural targets: no reset of their own, only a bench-controlled clear
  always @(posedge clock) begin
    tgt0 <= tgt_clr ? S0 : cex_next(tgt0, i0);
    tgt1 <= tgt_clr ? S0 : cex_next(tgt1, i1);
  end

  cex_driver u0 (.clock(clock), .reset(reset), .start(start0), .goal(goal), .p(p0), .q(q0),
    .i(i0), .busy(busy0), .done(done0), .fail(fail0), .err_code(err0), .steps(steps0),
    .trace_addr(trace_addr), .trace_data(td0));
  cex_driver #(.MAX_STEPS(2)) u1 (.clock(clock), .reset(reset), .start(start1), .goal(goal),
    .p(p1), .q(q1), .i(i1), .busy(busy1), .done(done1), .fail(fail1), .err_code(err1),
    .steps(steps1), .trace_addr(trace_addr), .trace_data(td1));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else pass++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; tgt_clr = 1'b1; ovr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; tgt_clr = 1'b0;
  endtask

  // start on a cycle where target is S1 so the first RUN cycle sees S0
  task automatic launch(input bit inst, input logic [1:0] g, input bit clr);
    bit got;
    sel = inst;
    if (clr) begin
      do_reset();
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++)
        if (tsel == S1) got = 1'b1; else @(negedge clock);
      if (!got) chk("align", 0, 1);
    end
    goal = g; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run(input int k);
    vec_t v, e;
    logic [7:0] obs;
    int n;
    bit got;
    v = tv[k];
    sb.push_back(v);
    launch(v.inst, v.goal, v.clr);
    obs = '0; n = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (bsy) begin obs[n[2:0]] = iw; n++; end
      start = v.poke && n == 2 && bsy;
      if (start) goal = 2'd1;
      if (dn || fl) got = 1'b1; else @(negedge clock);
    end
    start = 1'b0;
    chk($sformatf("v%0d complete", k), int'(got), 1);
    e = sb.pop_front();
    chk($sformatf("v%0d done", k), int'(dn), int'(e.done));
    chk($sformatf("v%0d fail", k), int'(fl), int'(!e.done));
    chk($sformatf("v%0d err_code", k), erw, e.err);
    chk($sformatf("v%0d steps", k), stw, e.steps);
    chk($sformatf("v%0d i_seq", k), int'(obs), int'(e.tr));
    chk($sformatf("v%0d run_cycles", k), n, e.steps + 1);
    if (e.tgt >= 0) chk($sformatf("v%0d target", k), int'(tsel), e.tgt);
    for (int a = 0; a < e.steps; a++) begin
      trace_addr = 4'(a);
      #1;
      chk($sformatf("v%0d trace[%0d]", k, a), int'(tdw), TR ? int'(e.tr[a]) : 0);
    end
  endtask

  initial begin
    //          inst clr poke goal done err steps tr     tgt
    tv[0] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 0, 3, 8'h06, 3};
    tv[1] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2, 0, 8'h00, 3};
    tv[2] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 0, 2, 8'h02, 2};
    tv[3] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 0, 0, 8'h00, 2};
    tv[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 0, 1, 8'h00, -1};
    tv[5] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 0, 0, 8'h00, -1};
    tv[6] = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 3, 2, 8'h02, 2};
    tv[7] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 0, 2, 8'h02, 2};
    tv[8] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 0, 3, 8'h06, 3};
    @(negedge clock);
    @(negedge clock);
    chk("rst busy", int'(busy0), 0);
    chk("rst done", int'(done0), 0);
    chk("rst fail", int'(fail0), 0);
    chk("rst i", int'(i0), 0);
    chk("rst err_code", int'(err0), 0);
    chk("rst steps", int'(steps0), 0);
    for (int k = 0; k < 9; k++) run(k);
    sel = 1'b0;
    // observed p dropped while shadow is S1
    launch(1'b0, 2'd3, 1'b1);
    @(negedge clock);
    ovr = 1'b1; pv = 1'b0; qv = 1'b0;
    @(negedge clock);
    ovr = 1'b0;
    chk("mm_p fail", int'(fail0), 1);
    chk("mm_p err_code", int'(err0), 1);
    chk("mm_p steps", int'(steps0), 1);
    // p and q both high
    launch(1'b0, 2'd3, 1'b1);
    ovr = 1'b1; pv = 1'b1; qv = 1'b1;
    @(negedge clock);
    ovr = 1'b0;
    chk("mm_pq fail", int'(fail0), 1);
    chk("mm_pq done", int'(done0), 0);
    chk("mm_pq err_code", int'(err0), 1);
    chk("mm_pq steps", int'(steps0), 0);
    // asynchronous reset mid-run, target left in S2
    launch(1'b0, 2'd3, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk("mid steps before", int'(steps0), 2);
    reset = 1'b1;
    #1;
    chk("mid busy", int'(busy0), 0);
    chk("mid i", int'(i0), 0);
    chk("mid steps", int'(steps0), 0);
    chk("mid done", int'(done0), 0);
    chk("mid fail", int'(fail0), 0);
    chk("mid err_code", int'(err0), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    goal = 2'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("post_rst fail", int'(fail0), 1);
    chk("post_rst err_code", int'(err0), 1);
    chk("post_rst target", int'(tgt0), 2);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/cex_driver.md
# cex_driver

Closed-loop stimulus driver for the cex target FSM: it observes the target's `p`/`q` outputs and drives its `i` input to steer the target into a requested goal state. The block keeps a shadow model of the 2-bit target state, checks each observed output against that model, and records the `i` sequence it drove as a replayable counterexample trace. It is the environment side of the target's single-input, two-flag interface and is used in benches and in on-chip self-check wrappers.

## Interface
- `MAX_STEPS`, default 15: step budget per run; must be ≥1.
- `DEPTH`, default 16: trace buffer entries; must be ≥ `MAX_STEPS`.
- `clock`, in, 1: single clock; all state updates on posedge.
- `reset`, in, 1: **asynchronous, active-high reset**.
- `start`, in, 1: begin a run; accepted in IDLE, DONE or FAIL.
- `goal`, in, 2: target state to reach; sampled on the accepted `start`.
- `p`, in, 1: target flag, high when the target is in S1.
- `q`, in, 1: target flag, high when the target is in S2.
- `i`, out, 1: drive to the target input.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `fail`, out, 1: high in FAIL.
- `err_code`, out, 2: failure cause. Encoding: 0 none, 1 mismatch, 2 unreachable, 3 timeout.
- `steps`, out, $clog2(MAX_STEPS+1): number of `i` values driven in the current or last run.
- `trace_addr`, in, $clog2(DEPTH): trace read address.
- `trace_data`, out, 1: recorded `i` at `trace_addr`.

## Operation
- **Shadow model.** A 2-bit register that free-runs in every FSM state using the `i` actually driven:
  - S0 → S1
  - S1 → S2 if `i`, else S0
  - S2 → S3 if `i`, else S2
  - S3 → S3
- **Expected flags.** `p` = (shadow == S1); `q` = (shadow == S2). `p` and `q` both high is always a mismatch.
- **Control FSM states:** IDLE, RUN, DONE, FAIL.
- **Start.** `start` in IDLE, DONE or FAIL does the following, then enters RUN:
  - latches `goal`;
  - clears `steps` and `err_code`.
- **RUN, evaluated once per cycle in priority order:**
  1. Observed `p`/`q` differ from expected → FAIL, code 1.
  2. shadow == goal → DONE.
  3. shadow == S3 and goal ≠ S3 → FAIL, code 2.
  4. `steps` == MAX_STEPS → FAIL, code 3.
  5. Otherwise: drive `i` per the policy, write `i` into trace[`steps`], and increment `steps`.
- **Drive policy** (combinational from registered shadow, latched goal and FSM state only; no path from `p`/`q`):
  - goal S2 or S3: `i` = 1 when shadow is S1 or S2.
  - goal S0 or S1: `i` = 0.
  - `i` = 0 in S0 and in all states other than RUN.
- **DONE and FAIL** hold their outputs and ignore `p`/`q` until the next `start`.
- **Reset mid-run:** the block returns to IDLE with shadow S0. The target has no reset, so if it was not restarted as well, the first RUN cycle flags a mismatch. This is the required behaviour, not an error in the driver.

## Timing
- **Reset values:**
  - FSM IDLE, shadow S0;
  - `i`, `busy`, `done`, `fail` = 0;
  - `err_code` = 0, `steps` = 0;
  - trace contents undefined. Only entries below `steps` are valid.
- **Start latency:** `busy` rises on the edge that samples `start`.
- **Cycle alignment:** in RUN cycle n, `i` reflects shadow(n). The target and the shadow both consume that `i` at the end of cycle n.
- **Completion latency:** `done`/`fail` assert one edge after the deciding cycle. `steps` is final at that same edge.
- **Budget boundary:** a goal reached exactly when `steps` == MAX_STEPS is DONE, not timeout, because the goal check has priority.
- **Immediate completion:** a goal equal to shadow on the first RUN cycle completes with `steps` = 0.
- **Trace read:** combinational from `trace_addr`. A write becomes visible the cycle after it is issued.

## Configuration
- Macro: `CEX_DRIVER_TRACE_EN`.
- **Defined:** DEPTH × 1 trace register file and read port present.
- **Undefined:** no storage is built and `trace_data` is tied to 0. `steps` and all control behaviour are unchanged.

## Structure
- **Shared package `cex_pkg`:**
  - state encoding S0–S3 (2'd0–2'd3);
  - FSM state enum;
  - `err_code` constants;
  - function `cex_next(state, i)` for the target transition, reused by the bench reference model.
- **One sub-module, `cex_shadow`:** shadow register plus expected-flag compare, producing `shadow` and `mismatch`.

## Test plan
- **Goal S3 from reset:** bench instantiates the cex target, `start`, goal=3 → `done` after 3 steps; trace = 0,1,1; `err_code` = 0.
- **Goal S2:** `start`, goal=2 → `done`, `steps` = 2, trace = 0,1; target `q` = 1 while DONE holds and `i` = 0.
- **Timeout:** MAX_STEPS=2, goal=3 → `fail`, `err_code` = 3, `steps` = 2, target in S2.
- **Unreachable:** after reaching S3, `start`, goal=1 → `fail`, `err_code` = 2, `steps` = 0, one edge after `start`.
- **Mismatch:** force `p`=0 while shadow is S1 during RUN → `fail`, `err_code` = 1 on the next edge; forcing `p`=`q`=1 gives the same result.
- **Reset and start edge cases:**
  - `reset` mid-run → all outputs return to reset values immediately (asynchronous);
  - `start` while `busy` is ignored.
